// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types and helpers for the rolly FIFO replay reader.
package bsg_fifo_rolly_pkg;

    typedef enum logic [1:0] {
        e_rr_hdr    = 2'd0,
        e_rr_send   = 2'd1,
        e_rr_wait   = 2'd2,
        e_rr_rewind = 2'd3
    } rr_state_e;

    // Extract the low lg_len bits of a header word (lg_len <= 32).
    function automatic logic [31:0] rr_hdr_len(input logic [31:0] hdr, input int unsigned lg_len);
        logic [31:0] mask;
        mask = (lg_len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << lg_len) - 32'd1);
        return hdr & mask;
    endfunction

endpackage

// File: rtl/bsg_rolly_resp_timer.sv
// Clearable saturating up-counter that flags when the response wait has expired.
module bsg_rolly_resp_timer
    import bsg_fifo_rolly_pkg::*;
#(
    parameter int unsigned timeout_p = 256
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned cnt_w_lp = $clog2(timeout_p + 1);

    logic [cnt_w_lp-1:0] cnt_q;

    assign expired_o = (cnt_q == cnt_w_lp'(timeout_p));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + cnt_w_lp'(1);
        end
    end

endmodule

// File: rtl/bsg_fifo_rolly_replay_reader.sv
// Streams length-headed packets out of a rolly FIFO and commits, replays or drops
// each one depending on the downstream ack/nack response.
module bsg_fifo_rolly_replay_reader
    import bsg_fifo_rolly_pkg::*;
#(
    parameter int unsigned width_p       = 16,
    parameter int unsigned lg_max_len_p  = 8,
    parameter int unsigned max_retries_p = 3,
    parameter int unsigned timeout_p     = 256
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [width_p-1:0]                 fifo_data_i,
    input  logic                               fifo_v_i,
    output logic                               fifo_yumi_o,
    output logic                               fifo_rollback_v_o,
    output logic                               fifo_ack_v_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               v_o,
    output logic                               last_o,
    input  logic                               ready_i,
    input  logic                               resp_v_i,
    input  logic                               resp_nack_i,
    output logic                               drop_o,
    output logic [$clog2(max_retries_p+1)-1:0] retry_cnt_o,
    output logic                               proto_err_o
);

    localparam int unsigned retry_w_lp = $clog2(max_retries_p + 1);

    rr_state_e                state_q, state_n;
    logic [lg_max_len_p-1:0]  rem_q, rem_n;
    logic [retry_w_lp-1:0]    retry_q, retry_n;
    logic                     proto_err_q;
    logic [lg_max_len_p-1:0]  hdr_len;
    logic                     expired;
    logic                     v_c, yumi_c, last_c, ack_c, rb_c, drop_c;

    assign hdr_len = lg_max_len_p'(rr_hdr_len(32'(fifo_data_i), lg_max_len_p));
    assign yumi_c  = v_c & ready_i;

    bsg_rolly_resp_timer #(.timeout_p(timeout_p)) timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (state_q != e_rr_wait),
        .en_i      (state_q == e_rr_wait),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_rr_hdr;
            rem_q       <= '0;
            retry_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
            retry_q <= retry_n;
            if (resp_v_i && (state_q != e_rr_wait)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        retry_n = retry_q;
        v_c     = 1'b0;
        last_c  = 1'b0;
        ack_c   = 1'b0;
        rb_c    = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            e_rr_hdr: begin
                v_c = fifo_v_i;
                if (fifo_v_i && ready_i) begin
                    rem_n = hdr_len;
                    if (hdr_len == '0) begin
                        last_c  = 1'b1;
                        state_n = e_rr_wait;
                    end else begin
                        state_n = e_rr_send;
                    end
                end
            end
            e_rr_send: begin
                v_c    = fifo_v_i;
                last_c = (rem_q == lg_max_len_p'(1));
                if (fifo_v_i && ready_i) begin
                    rem_n = rem_q - lg_max_len_p'(1);
                    if (last_c) begin
                        state_n = e_rr_wait;
                    end
                end
            end
            e_rr_wait: begin
                // An explicit ack beats a nack or a coincident timeout.
                if (resp_v_i && !resp_nack_i) begin
                    ack_c   = 1'b1;
                    retry_n = '0;
                    state_n = e_rr_hdr;
                end else if (resp_v_i || expired) begin
                    if (retry_q < retry_w_lp'(max_retries_p)) begin
                        rb_c    = 1'b1;
                        retry_n = retry_q + retry_w_lp'(1);
                        state_n = e_rr_rewind;
                    end else begin
                        ack_c   = 1'b1;
                        drop_c  = 1'b1;
                        retry_n = '0;
                        state_n = e_rr_hdr;
                    end
                end
            end
            e_rr_rewind: begin
                state_n = e_rr_hdr;
            end
            default: begin
                state_n = e_rr_hdr;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign data_o            = fifo_data_i & {width_p{reset_n_i}};
    assign v_o               = v_c & reset_n_i;
    assign fifo_yumi_o       = yumi_c & reset_n_i;
    assign last_o            = last_c & reset_n_i;
    assign fifo_ack_v_o      = ack_c & reset_n_i;
    assign fifo_rollback_v_o = rb_c & reset_n_i;
    assign drop_o            = drop_c & reset_n_i;
    assign retry_cnt_o       = retry_q;
    assign proto_err_o       = proto_err_q;

endmodule
